// File: rtl/uc_sequenciador_frame_pkg.sv
// pkg_astrogenius: definitions shared by the frame sequencer and its helpers.
//
// Contents:
//   estado_t            state encoding of the frame sequencer
//                       (its codes also drive db_estado_sequenciador)
//   PERDIDOS_MAX        saturation value of the lost-frame counter
//   eh_fase()           true in the five phase states (registra_tiro..render)
//   conta_atraso()      true in the states where a frame tick counts as overrun
//   aceita_iniciar()    true in the states that can (re)start a game
package pkg_astrogenius;

  typedef enum logic [3:0] {
    ST_INICIAL         = 4'd0,
    ST_ESPERA_INICIO   = 4'd1,
    ST_ESPERA_TICK     = 4'd2,
    ST_REGISTRA_TIRO   = 4'd3,
    ST_MOVE_TIROS      = 4'd4,
    ST_MOVE_ASTEROIDES = 4'd5,
    ST_COLISAO         = 4'd6,
    ST_RENDER          = 4'd7,
    ST_FRAME_FIM       = 4'd8,
    ST_FIM_DE_JOGO     = 4'd9,
    ST_ERRO            = 4'd10
  } estado_t;

  localparam logic [7:0] PERDIDOS_MAX = 8'd255;

  // Phase states are the ones that raise an inicia_* request and wait for fim_*.
  function automatic logic eh_fase(input estado_t e);
    return (e >= ST_REGISTRA_TIRO) && (e <= ST_RENDER);
  endfunction

  // A tick arriving while a frame is still being processed (phases or the
  // end-of-frame cycle) means the frame ran late.
  function automatic logic conta_atraso(input estado_t e);
    return (e >= ST_REGISTRA_TIRO) && (e <= ST_FRAME_FIM);
  endfunction

  // States that wait for iniciar to begin a fresh game.
  function automatic logic aceita_iniciar(input estado_t e);
    return (e == ST_ESPERA_INICIO) || (e == ST_FIM_DE_JOGO) || (e == ST_ERRO);
  endfunction

endpackage

// File: rtl/uc_sequenciador_frame_watchdog.sv
// contador_watchdog: counts cycles spent in the current sequencer state.
//
// Only present in the WATCHDOG_EN build.
//
// Parameters:
//   TIMEOUT   number of cycles a state may last before estourou rises
// Ports:
//   clock     rising-edge clock
//   reset     synchronous active-high reset
//   limpa     restart the count (asserted on the edge that enters a new state)
//   estourou  high while the current state has lasted TIMEOUT cycles
`ifdef WATCHDOG_EN
module contador_watchdog #(
  parameter int TIMEOUT = 833333
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  output logic estourou
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT - 1);

  logic [W-1:0] ciclos;

  // ciclos is 0 on the first cycle of a state, so reaching LIMITE means the
  // state is in its TIMEOUT-th cycle; the count then holds there until cleared.
  always_ff @(posedge clock) begin
    if (reset || limpa) begin
      ciclos <= '0;
    end else if (ciclos != LIMITE) begin
      ciclos <= ciclos + W'(1);
    end
  end

  assign estourou = (ciclos == LIMITE);

endmodule
`endif

// File: rtl/uc_sequenciador_frame.sv
// uc_sequenciador_frame: per-frame sequencer of the game control unit.
//
// Waits for the game to start, then on every frame tick runs the five
// processing phases in order (shot registration, shot movement, asteroid
// movement, collision, render), each by holding its inicia_* high until the
// matching fim_* returns. Ticks that arrive while a frame is still running are
// counted as lost frames and one of them is kept pending so the next frame
// starts as soon as the current one ends.
//
// Configuration macro:
//   WATCHDOG_EN  when defined, a phase that waits TIMEOUT cycles without its
//                fim_* sends the sequencer to the erro state (erro=1).
//                When undefined, phases wait indefinitely and erro is 0.
//
// Parameters:
//   TIMEOUT  watchdog limit in cycles (WATCHDOG_EN build only)
//   FRAME_W  width of contador_frames
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   iniciar                            start / restart the game
//   tick_frame                         one-cycle frame-rate pulse
//   fim_jogo                           game-over level, sampled at frame end
//   inicia_tiro .. inicia_render       phase request levels
//   fim_tiro .. fim_render             phase done inputs
//   frame_pronto                       one-cycle end-of-frame pulse
//   contador_frames                    completed frames (wraps)
//   frames_perdidos                    overrun ticks (saturates at 255)
//   erro                               watchdog error indication
//   db_estado_sequenciador             current state code, for debug
import pkg_astrogenius::*;

module uc_sequenciador_frame #(
  parameter int TIMEOUT = 833333,
  parameter int FRAME_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               iniciar,
  input  logic               tick_frame,
  input  logic               fim_jogo,
  output logic               inicia_tiro,
  output logic               inicia_mov_tiros,
  output logic               inicia_mov_ast,
  output logic               inicia_colisao,
  output logic               inicia_render,
  input  logic               fim_tiro,
  input  logic               fim_mov_tiros,
  input  logic               fim_mov_ast,
  input  logic               fim_colisao,
  input  logic               fim_render,
  output logic               frame_pronto,
  output logic [FRAME_W-1:0] contador_frames,
  output logic [7:0]         frames_perdidos,
  output logic               erro,
  output logic [3:0]         db_estado_sequenciador
);

  if (FRAME_W < 1 || TIMEOUT < 1) begin : g_parametros_invalidos
    $error("uc_sequenciador_frame: FRAME_W and TIMEOUT must both be at least 1");
  end

  estado_t estado;
  estado_t proximo;
  logic    pendente;
  logic    limpa_contadores;

`ifdef WATCHDOG_EN
  logic estourou;

  // The count restarts on every state change, so it always measures the
  // time spent in the state the sequencer is currently in.
  contador_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .limpa    (proximo != estado),
    .estourou (estourou)
  );
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ST_INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  // Next-state logic. Each phase only listens to its own fim_*; the other
  // done inputs are don't-cares while it waits.
  always_comb begin
    proximo = estado;
    case (estado)
      ST_INICIAL: begin
        proximo = ST_ESPERA_INICIO;
      end
      ST_ESPERA_INICIO, ST_FIM_DE_JOGO, ST_ERRO: begin
        if (iniciar) proximo = ST_ESPERA_TICK;
      end
      ST_ESPERA_TICK: begin
        if (tick_frame || pendente) proximo = ST_REGISTRA_TIRO;
      end
      ST_REGISTRA_TIRO: begin
        if (fim_tiro) proximo = ST_MOVE_TIROS;
      end
      ST_MOVE_TIROS: begin
        if (fim_mov_tiros) proximo = ST_MOVE_ASTEROIDES;
      end
      ST_MOVE_ASTEROIDES: begin
        if (fim_mov_ast) proximo = ST_COLISAO;
      end
      ST_COLISAO: begin
        if (fim_colisao) proximo = ST_RENDER;
      end
      ST_RENDER: begin
        if (fim_render) proximo = ST_FRAME_FIM;
      end
      ST_FRAME_FIM: begin
        proximo = fim_jogo ? ST_FIM_DE_JOGO : ST_ESPERA_TICK;
      end
      default: begin
        proximo = ST_INICIAL;
      end
    endcase
`ifdef WATCHDOG_EN
    // A phase that is still waiting (no advance decided above) when its time
    // runs out is abandoned; a fim_* in that same cycle still wins.
    if (eh_fase(estado) && (proximo == estado) && estourou) begin
      proximo = ST_ERRO;
    end
`endif
  end

  assign limpa_contadores = aceita_iniciar(estado) && iniciar;

  // Frame bookkeeping. Starting a game clears everything; otherwise the frame
  // counter advances once per end-of-frame cycle, and a tick during a running
  // frame is both counted as lost and remembered as a single pending start.
  always_ff @(posedge clock) begin
    if (reset) begin
      contador_frames <= '0;
      frames_perdidos <= '0;
      pendente        <= 1'b0;
    end else if (limpa_contadores) begin
      contador_frames <= '0;
      frames_perdidos <= '0;
      pendente        <= 1'b0;
    end else begin
      if (estado == ST_FRAME_FIM) begin
        contador_frames <= contador_frames + {{(FRAME_W-1){1'b0}}, 1'b1};
      end
      if ((estado == ST_ESPERA_TICK) && (proximo == ST_REGISTRA_TIRO)) begin
        pendente <= 1'b0;
      end
      if (conta_atraso(estado) && tick_frame) begin
        pendente <= 1'b1;
        if (frames_perdidos != PERDIDOS_MAX) begin
          frames_perdidos <= frames_perdidos + 8'd1;
        end
      end
    end
  end

  // Moore outputs, decoded straight from the registered state.
  assign inicia_tiro            = (estado == ST_REGISTRA_TIRO);
  assign inicia_mov_tiros       = (estado == ST_MOVE_TIROS);
  assign inicia_mov_ast         = (estado == ST_MOVE_ASTEROIDES);
  assign inicia_colisao         = (estado == ST_COLISAO);
  assign inicia_render          = (estado == ST_RENDER);
  assign frame_pronto           = (estado == ST_FRAME_FIM);
  assign db_estado_sequenciador = estado;

`ifdef WATCHDOG_EN
  assign erro = (estado == ST_ERRO);
`else
  assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_uc_sequenciador_frame.sv
// Self-checking bench for uc_sequenciador_frame (built with FRAME_W=4, TIMEOUT=8).
// Frame completions are scoreboarded: each started frame pushes its expected
// frame count, and a monitor pops it one cycle after frame_pronto.
module tb_uc_sequenciador_frame;

  localparam int FRAME_W = 4;
  localparam int TIMEOUT = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               iniciar = 1'b0;
  logic               tick_frame = 1'b0;
  logic               fim_jogo = 1'b0;
  logic [4:0]         fim_vec = 5'b0;
  wire  [4:0]         inicia_vec;
  wire                frame_pronto;
  wire  [FRAME_W-1:0] contador_frames;
  wire  [7:0]         frames_perdidos;
  wire                erro;
  wire  [3:0]         db_estado;

  int tests_run = 0;
  int tests_failed = 0;
  int model_frames = 0;
  int model_perdidos = 0;
  int exp_q[$];
  int exp_cnt;
  logic pronto_d = 1'b0;

  uc_sequenciador_frame #(
    .TIMEOUT (TIMEOUT),
    .FRAME_W (FRAME_W)
  ) dut (
    .clock                  (clock),
    .reset                  (reset),
    .iniciar                (iniciar),
    .tick_frame             (tick_frame),
    .fim_jogo               (fim_jogo),
    .inicia_tiro            (inicia_vec[0]),
    .inicia_mov_tiros       (inicia_vec[1]),
    .inicia_mov_ast         (inicia_vec[2]),
    .inicia_colisao         (inicia_vec[3]),
    .inicia_render          (inicia_vec[4]),
    .fim_tiro               (fim_vec[0]),
    .fim_mov_tiros          (fim_vec[1]),
    .fim_mov_ast            (fim_vec[2]),
    .fim_colisao            (fim_vec[3]),
    .fim_render             (fim_vec[4]),
    .frame_pronto           (frame_pronto),
    .contador_frames        (contador_frames),
    .frames_perdidos        (frames_perdidos),
    .erro                   (erro),
    .db_estado_sequenciador (db_estado)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: the cycle after an end-of-frame pulse the frame count
  // must equal the value queued when that frame was started.
  always @(negedge clock) begin
    if (reset) begin
      pronto_d <= 1'b0;
    end else begin
      if (pronto_d) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL sb_frame: unexpected frame_pronto, contador_frames=%0d", contador_frames);
        end else begin
          exp_cnt = exp_q.pop_front();
          if (contador_frames !== FRAME_W'(exp_cnt)) begin
            tests_failed++;
            $display("[TB] FAIL sb_frame: contador_frames=%0d expected %0d", contador_frames, exp_cnt);
          end
        end
      end
      pronto_d <= frame_pronto;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got stuck expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Runs one frame starting in registra_tiro, answering each request one
  // cycle after it appears; ticks_ast extra cycles with a tick are spent in
  // move_asteroides before its done is given.
  task automatic run_frame(input int ticks_ast, input bit encerra);
    model_frames = (model_frames + 1) % (1 << FRAME_W);
    exp_q.push_back(model_frames);
    for (int p = 0; p < 5; p++) begin
      tests_run++;
      if (db_estado !== 4'(p + 3)) begin
        tests_failed++;
        $display("[TB] FAIL frame_state: state=%0d expected %0d", db_estado, p + 3);
      end
      tests_run++;
      if (inicia_vec !== 5'(1 << p)) begin
        tests_failed++;
        $display("[TB] FAIL frame_inicia: inicia=%b expected %b", inicia_vec, 5'(1 << p));
      end
      if (p == 2) begin
        for (int k = 0; k < ticks_ast; k++) begin
          tick_frame = 1'b1;
          next_cycle();
          tick_frame = 1'b0;
          if (model_perdidos < 255) model_perdidos++;
        end
      end
      fim_vec  = 5'(1 << p);
      fim_jogo = encerra;
      next_cycle();
      fim_vec  = 5'b0;
    end
    tests_run++;
    if (db_estado !== 4'd8 || frame_pronto !== 1'b1 || inicia_vec !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL frame_fim: state=%0d pronto=%b inicia=%b expected 8/1/00000",
               db_estado, frame_pronto, inicia_vec);
    end
    next_cycle();
    fim_jogo = 1'b0;
    tests_run++;
    if (frame_pronto !== 1'b0 || db_estado !== (encerra ? 4'd9 : 4'd2)) begin
      tests_failed++;
      $display("[TB] FAIL frame_after: state=%0d pronto=%b expected %0d/0",
               db_estado, frame_pronto, encerra ? 9 : 2);
    end
    tests_run++;
    if (frames_perdidos !== 8'(model_perdidos)) begin
      tests_failed++;
      $display("[TB] FAIL frame_perdidos: frames_perdidos=%0d expected %0d", frames_perdidos, model_perdidos);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd0 || inicia_vec !== 5'b0 || frame_pronto !== 1'b0 || erro !== 1'b0 ||
        contador_frames !== '0 || frames_perdidos !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: state=%0d inicia=%b pronto=%b erro=%b cnt=%0d lost=%0d expected all 0",
               db_estado, inicia_vec, frame_pronto, erro, contador_frames, frames_perdidos);
    end
    reset = 1'b0;
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL reset_exit: state=%0d expected 1", db_estado);
    end
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    tests_run++;
    if (db_estado !== 4'd1 || frames_perdidos !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL idle_tick: state=%0d lost=%0d expected 1/0", db_estado, frames_perdidos);
    end
  endtask

  task automatic test_frame();
    iniciar = 1'b1;
    next_cycle();
    iniciar = 1'b0;
    tests_run++;
    if (db_estado !== 4'd2 || contador_frames !== '0) begin
      tests_failed++;
      $display("[TB] FAIL start: state=%0d cnt=%0d expected 2/0", db_estado, contador_frames);
    end
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    fim_vec = 5'b11110;
    next_cycle();
    fim_vec = 5'b0;
    tests_run++;
    if (db_estado !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL foreign_fim: state=%0d expected 3", db_estado);
    end
    run_frame(0, 1'b0);
    tests_run++;
    if (contador_frames !== FRAME_W'(1)) begin
      tests_failed++;
      $display("[TB] FAIL frame_count: cnt=%0d expected 1", contador_frames);
    end
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL no_tick_wait: state=%0d expected 2", db_estado);
    end
  endtask

  task automatic test_overrun();
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    run_frame(2, 1'b0);
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL pending_start: state=%0d expected 3", db_estado);
    end
    run_frame(0, 1'b0);
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL single_pending: state=%0d expected 2", db_estado);
    end
  endtask

  task automatic test_saturation();
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    run_frame(300, 1'b0);
    tests_run++;
    if (frames_perdidos !== 8'd255) begin
      tests_failed++;
      $display("[TB] FAIL lost_saturate: lost=%0d expected 255", frames_perdidos);
    end
    next_cycle();
    run_frame(0, 1'b0);
  endtask

  task automatic test_game_over();
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    run_frame(0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick_frame = 1'b1;
      next_cycle();
      tick_frame = 1'b0;
      tests_run++;
      if (db_estado !== 4'd9 || frames_perdidos !== 8'(model_perdidos) || inicia_vec !== 5'b0) begin
        tests_failed++;
        $display("[TB] FAIL game_over_tick: state=%0d lost=%0d inicia=%b expected 9/%0d/00000",
                 db_estado, frames_perdidos, inicia_vec, model_perdidos);
      end
    end
    iniciar = 1'b1;
    next_cycle();
    iniciar = 1'b0;
    model_frames = 0;
    model_perdidos = 0;
    tests_run++;
    if (db_estado !== 4'd2 || contador_frames !== '0 || frames_perdidos !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL restart: state=%0d cnt=%0d lost=%0d expected 2/0/0",
               db_estado, contador_frames, frames_perdidos);
    end
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL restart_no_pending: state=%0d expected 2", db_estado);
    end
  endtask

  task automatic test_reset_mid_phase();
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    run_frame(1, 1'b0);
    next_cycle();
    for (int p = 0; p < 3; p++) begin
      fim_vec = 5'(1 << p);
      next_cycle();
      fim_vec = 5'b0;
    end
    tests_run++;
    if (db_estado !== 4'd6 || inicia_vec !== 5'b01000) begin
      tests_failed++;
      $display("[TB] FAIL reach_colisao: state=%0d inicia=%b expected 6/01000", db_estado, inicia_vec);
    end
    reset = 1'b1;
    fim_vec = 5'b01000;
    tick_frame = 1'b1;
    next_cycle();
    reset = 1'b0;
    fim_vec = 5'b0;
    tick_frame = 1'b0;
    model_frames = 0;
    model_perdidos = 0;
    tests_run++;
    if (db_estado !== 4'd0 || inicia_vec !== 5'b0 || contador_frames !== '0 ||
        frames_perdidos !== 8'd0 || frame_pronto !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: state=%0d inicia=%b cnt=%0d lost=%0d pronto=%b expected all 0",
               db_estado, inicia_vec, contador_frames, frames_perdidos, frame_pronto);
    end
    next_cycle();
    iniciar = 1'b1;
    next_cycle();
    iniciar = 1'b0;
    tests_run++;
    if (db_estado !== 4'd2) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_restart: state=%0d expected 2", db_estado);
    end
  endtask

  task automatic test_wrap();
    for (int f = 0; f < 15; f++) begin
      tick_frame = 1'b1;
      next_cycle();
      tick_frame = 1'b0;
      run_frame(0, 1'b0);
    end
    tests_run++;
    if (contador_frames !== FRAME_W'(15)) begin
      tests_failed++;
      $display("[TB] FAIL wrap_preload: cnt=%0d expected 15", contador_frames);
    end
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    run_frame(0, 1'b0);
    tests_run++;
    if (contador_frames !== '0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_zero: cnt=%0d expected 0", contador_frames);
    end
  endtask

`ifdef WATCHDOG_EN
  task automatic test_watchdog();
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    for (int p = 0; p < 4; p++) begin
      fim_vec = 5'(1 << p);
      next_cycle();
      fim_vec = 5'b0;
    end
    for (int k = 1; k < TIMEOUT; k++) begin
      next_cycle();
      tests_run++;
      if (db_estado !== 4'd7 || erro !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL wd_wait: state=%0d erro=%b expected 7/0 at cycle %0d", db_estado, erro, k);
      end
    end
    next_cycle();
    tests_run++;
    if (db_estado !== 4'd10 || erro !== 1'b1 || inicia_vec !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL wd_timeout: state=%0d erro=%b inicia=%b expected 10/1/00000",
               db_estado, erro, inicia_vec);
    end
    tick_frame = 1'b1;
    next_cycle();
    tick_frame = 1'b0;
    tests_run++;
    if (db_estado !== 4'd10 || frames_perdidos !== 8'(model_perdidos)) begin
      tests_failed++;
      $display("[TB] FAIL wd_tick: state=%0d lost=%0d expected 10/%0d", db_estado, frames_perdidos, model_perdidos);
    end
    iniciar = 1'b1;
    next_cycle();
    iniciar = 1'b0;
    tests_run++;
    if (db_estado !== 4'd2 || erro !== 1'b0 || contador_frames !== '0) begin
      tests_failed++;
      $display("[TB] FAIL wd_restart: state=%0d erro=%b cnt=%0d expected 2/0/0", db_estado, erro, contador_frames);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_saturation();
    test_game_over();
    test_reset_mid_phase();
    test_wrap();
`ifdef WATCHDOG_EN
    test_watchdog();
`endif
    next_cycle();
    next_cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL sb_drain: %0d frames still expected, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uc_sequenciador_frame.md
UC_SEQUENCIADOR_FRAME -- requirements
Module: uc_sequenciador_frame

Interface
REQ-001 SHALL have parameter TIMEOUT, default 833333, max cycles a phase may wait for its done signal (watchdog build only).
REQ-002 SHALL have parameter FRAME_W, default 16, width of frame counter.
REQ-003 SHALL have port clock  in  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports iniciar in 1 game start; tick_frame in 1 one-cycle frame-rate pulse; fim_jogo in 1 game-over level.
REQ-006 SHALL have request outputs inicia_tiro, inicia_mov_tiros, inicia_mov_ast, inicia_colisao, inicia_render, each out 1.
REQ-007 SHALL have done inputs fim_tiro, fim_mov_tiros, fim_mov_ast, fim_colisao, fim_render, each in 1.
REQ-008 SHALL have outputs frame_pronto out 1 (end-of-frame pulse), contador_frames out FRAME_W, frames_perdidos out 8, erro out 1, db_estado_sequenciador out 4.

Function
REQ-009 SHALL be a Moore FSM with states: inicial 0, espera_inicio 1, espera_tick 2, registra_tiro 3, move_tiros 4, move_asteroides 5, colisao 6, render 7, frame_fim 8, fim_de_jogo 9, erro 10; db_estado_sequenciador = state code.
REQ-010 inicial SHALL go to espera_inicio unconditionally next cycle.
REQ-011 espera_inicio SHALL go to espera_tick when iniciar=1, clearing contador_frames, frames_perdidos and tick pending flag; tick_frame ignored here.
REQ-012 espera_tick SHALL go to registra_tiro when tick_frame=1 or pending flag=1; pending flag cleared on that transition.
REQ-013 Phase states 3..7 SHALL hold their own inicia_* high as a level for the whole stay; all other inicia_* low.
REQ-014 Each phase state SHALL advance (3->4->5->6->7->8) on the edge where its own fim_* is sampled 1; other fim_* ignored.
REQ-015 A phase SHALL last at least 1 cycle; fim_* high on the entry cycle advances at the next edge.
REQ-016 frame_fim SHALL assert frame_pronto for exactly 1 cycle and increment contador_frames (wraps at 2^FRAME_W-1 -> 0).
REQ-017 frame_fim SHALL go to fim_de_jogo if fim_jogo=1, else espera_tick.
REQ-018 fim_de_jogo SHALL hold all inicia_* low and go to espera_tick with counter clear as in REQ-011 when iniciar=1.
REQ-019 tick_frame=1 in states 3..8 SHALL set pending flag and increment frames_perdidos, saturating at 255.
REQ-020 Only one tick SHALL be pending; further overrun ticks only increment frames_perdidos.
REQ-021 tick_frame in states 0,1,9,10 SHALL be ignored and not counted.

Reset
REQ-022 reset=1 at an edge SHALL force state inicial, all inicia_* 0, frame_pronto 0, erro 0, counters 0, pending 0, overriding every other input, including mid-phase.
REQ-023 Outputs SHALL reflect reset values from the edge at which reset is sampled.

Configuration
REQ-024 Macro WATCHDOG_EN defined: cycle counter cleared on every state entry; in states 3..7, reaching TIMEOUT cycles without fim_* SHALL go to erro.
REQ-025 In erro: erro=1, all inicia_* 0; exit only by reset or iniciar=1 (to espera_tick per REQ-011).
REQ-026 WATCHDOG_EN undefined: no counter, erro tied 0, erro state unreachable, phases wait indefinitely.

Structure
REQ-027 State encodings SHALL live in shared package pkg_astrogenius.
REQ-028 Watchdog counter SHALL be sub-module contador_watchdog, instantiated only under WATCHDOG_EN.

Verification
REQ-029 iniciar, tick, each fim_* 1 cycle after its inicia_* -> states 2..8 in order, frame_pronto one pulse, contador_frames=1.
REQ-030 Two ticks during move_asteroides -> frames_perdidos=2, next frame starts 1 cycle after entering espera_tick without new tick.
REQ-031 fim_jogo=1 at frame_fim -> state 9, ticks ignored; iniciar -> state 2, counters 0.
REQ-032 reset asserted during colisao -> next cycle state 0, inicia_colisao 0, counters 0.
REQ-033 WATCHDOG_EN, TIMEOUT=8, fim_render never -> erro=1 after 8 cycles in render, state 10.
REQ-034 Preload contador_frames=0xFFFF by running frames (FRAME_W=4 build: 15 frames) -> next frame_fim wraps to 0.
